// File: rtl/mips_eu_sequencer.sv
// Multi-cycle control FSM for the MIPS execution unit: fetch handshake, EU controls, RAM handshake.
// Optional performance counters (retired_cnt, stall_cnt) are built when EU_SEQ_PERF_EN is defined.
module mips_eu_sequencer #(
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        instr_valid,
   output logic        instr_ready,
   input  logic [5:0]  opcode,
   input  logic        Zero,
   input  logic        mem_ack,
   output logic        mem_req,
   output logic        mem_we,
   output logic        RegDst,
   output logic        ALUSrc,
   output logic [1:0]  ALUOp,
   output logic        RegWrite,
   output logic        MemtoReg,
   output logic        branch_taken,
   output logic        illegal_op,
   output logic        bus_err
`ifdef EU_SEQ_PERF_EN
   ,
   output logic [31:0] retired_cnt,
   output logic [31:0] stall_cnt
`endif
);

   localparam logic [5:0] OP_R    = 6'h00;
   localparam logic [5:0] OP_ADDI = 6'h08;
   localparam logic [5:0] OP_LW   = 6'h23;
   localparam logic [5:0] OP_SW   = 6'h2B;
   localparam logic [5:0] OP_BEQ  = 6'h04;
   localparam logic [8:0] TMO_LIMIT = 9'(MEM_TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB
   } state_t;

   state_t      state_q, state_d;
   logic [5:0]  op_q;
   logic [7:0]  tmo_q, tmo_d;
   logic [8:0]  tmo_inc;
   logic        br_d, ill_d, berr_d;
   logic        ctl_act;
   logic        op_ok;

   always_comb begin
      state_d = state_q;
      tmo_d   = '0;
      tmo_inc = {1'b0, tmo_q} + 9'd1;
      br_d    = 1'b0;
      ill_d   = 1'b0;
      berr_d  = 1'b0;
      op_ok   = op_q inside {OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ};
      case (state_q)
         S_IDLE: begin
            if (instr_valid && instr_ready) state_d = S_DECODE;
         end
         S_DECODE: begin
            if (op_ok) begin
               state_d = S_EXEC;
            end else begin
               ill_d   = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_EXEC: begin
            case (op_q)
               OP_R, OP_ADDI: state_d = S_WB;
               OP_LW, OP_SW:  state_d = S_MEM;
               default: begin
                  // only beq reaches here; Zero is sampled on the way out
                  br_d    = Zero;
                  state_d = S_IDLE;
               end
            endcase
         end
         S_MEM: begin
            // an ack arriving on the timeout cycle still completes the access
            if (mem_ack) begin
               state_d = (op_q == OP_LW) ? S_WB : S_IDLE;
            end else if (tmo_inc >= TMO_LIMIT) begin
               berr_d  = 1'b1;
               state_d = S_IDLE;
            end else begin
               tmo_d = tmo_inc[7:0];
            end
         end
         S_WB:    state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      ctl_act = (state_d == S_EXEC) || (state_d == S_MEM) || (state_d == S_WB);
   end

   // Outputs are registered from the next state, so they line up with the state they describe.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         tmo_q        <= '0;
         instr_ready  <= 1'b0;
         mem_req      <= 1'b0;
         mem_we       <= 1'b0;
         RegDst       <= 1'b0;
         ALUSrc       <= 1'b0;
         ALUOp        <= 2'b00;
         RegWrite     <= 1'b0;
         MemtoReg     <= 1'b0;
         branch_taken <= 1'b0;
         illegal_op   <= 1'b0;
         bus_err      <= 1'b0;
      end else begin
         state_q      <= state_d;
         tmo_q        <= tmo_d;
         instr_ready  <= (state_d == S_IDLE);
         mem_req      <= (state_d == S_MEM);
         mem_we       <= ctl_act && (op_q == OP_SW);
         RegDst       <= ctl_act && (op_q == OP_R);
         ALUSrc       <= ctl_act && ((op_q == OP_ADDI) || (op_q == OP_LW) || (op_q == OP_SW));
         ALUOp        <= !ctl_act          ? 2'b00 :
                         (op_q == OP_R)    ? 2'b10 :
                         (op_q == OP_BEQ)  ? 2'b01 : 2'b00;
         RegWrite     <= (state_d == S_WB);
         MemtoReg     <= ctl_act && (op_q == OP_LW);
         branch_taken <= br_d;
         illegal_op   <= ill_d;
         bus_err      <= berr_d;
      end
   end

   // Opcode is datapath; it is only meaningful after an accept, so it carries no reset.
   always_ff @(posedge clk) begin
      if ((state_q == S_IDLE) && instr_valid && instr_ready) op_q <= opcode;
   end

`ifdef EU_SEQ_PERF_EN
   logic retire, stall;

   always_comb begin
      retire = (state_q == S_WB) ||
               ((state_q == S_EXEC) && (op_q == OP_BEQ)) ||
               ((state_q == S_MEM) && mem_ack && (op_q == OP_SW));
      stall  = (state_q == S_MEM) && !mem_ack;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         retired_cnt <= '0;
         stall_cnt   <= '0;
      end else begin
         if (retire) retired_cnt <= retired_cnt + 32'd1;
         if (stall)  stall_cnt   <= stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mips_eu_sequencer.sv
// Self-checking bench for mips_eu_sequencer: directed scenarios plus randomized ops against a timeline model.
module tb_mips_eu_sequencer;
   localparam int TMO = 15;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        instr_valid;
   logic        instr_ready;
   logic [5:0]  opcode;
   logic        Zero;
   logic        mem_ack;
   logic        mem_req, mem_we, RegDst, ALUSrc, RegWrite, MemtoReg;
   logic [1:0]  ALUOp;
   logic        branch_taken, illegal_op, bus_err;
`ifdef EU_SEQ_PERF_EN
   logic [31:0] retired_cnt, stall_cnt;
`endif

   always #5 clk = ~clk;

   mips_eu_sequencer #(.MEM_TIMEOUT(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .opcode(opcode), .Zero(Zero), .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we),
      .RegDst(RegDst), .ALUSrc(ALUSrc), .ALUOp(ALUOp), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
      .branch_taken(branch_taken), .illegal_op(illegal_op), .bus_err(bus_err)
`ifdef EU_SEQ_PERF_EN
      , .retired_cnt(retired_cnt), .stall_cnt(stall_cnt)
`endif
   );

   // Observation vector: {ready, mem_req, mem_we, RegDst, ALUSrc, ALUOp[1:0], RegWrite, MemtoReg, br, ill, berr}
   localparam logic [11:0] B_RDY  = 12'h800;
   localparam logic [11:0] B_REQ  = 12'h400;
   localparam logic [11:0] B_RW   = 12'h010;
   localparam logic [11:0] B_BR   = 12'h004;
   localparam logic [11:0] B_ILL  = 12'h002;
   localparam logic [11:0] B_BERR = 12'h001;

   int          n_checks = 0;
   int          n_fail = 0;
   logic [11:0] exp_v [0:31];
   logic [11:0] obs_v [0:31];
   int          exp_len;
   int unsigned m_retired = 0;
   int unsigned m_stall = 0;

   function automatic logic [11:0] pack_obs();
      return {instr_ready, mem_req, mem_we, RegDst, ALUSrc, ALUOp, RegWrite, MemtoReg,
              branch_taken, illegal_op, bus_err};
   endfunction

   // Control encoding table for each supported opcode.
   function automatic logic [11:0] ctl_of(input logic [5:0] op);
      logic [11:0] v;
      v = '0;
      case (op)
         6'h00: begin v[8] = 1'b1; v[6:5] = 2'b10; end             // R: RegDst, ALUOp=10
         6'h08: begin v[7] = 1'b1; end                              // addi: ALUSrc
         6'h23: begin v[7] = 1'b1; v[3] = 1'b1; end                 // lw: ALUSrc, MemtoReg
         6'h2B: begin v[7] = 1'b1; v[9] = 1'b1; end                 // sw: ALUSrc, mem_we
         6'h04: begin v[6:5] = 2'b01; end                           // beq: ALUOp=01
         default: v = '0;
      endcase
      return v;
   endfunction

   function automatic bit supported(input logic [5:0] op);
      return (op == 6'h00) || (op == 6'h08) || (op == 6'h23) || (op == 6'h2B) || (op == 6'h04);
   endfunction

   // Timeline model: cycle c (1-based after the accept edge) -> expected observation vector.
   task automatic model(input logic [5:0] op, input bit zero, input int ack_at);
      logic [11:0] cv;
      bit          acked;
      int          n;
      cv = ctl_of(op);
      exp_len = 1;
      exp_v[1] = '0;
      if (!supported(op)) begin
         exp_len++; exp_v[exp_len] = B_RDY | B_ILL;
      end else begin
         exp_len++; exp_v[exp_len] = cv;
         if (op == 6'h00 || op == 6'h08) begin
            exp_len++; exp_v[exp_len] = cv | B_RW;
            exp_len++; exp_v[exp_len] = B_RDY;
            m_retired++;
         end else if (op == 6'h04) begin
            exp_len++; exp_v[exp_len] = B_RDY | (zero ? B_BR : 12'h000);
            m_retired++;
         end else begin
            acked = (ack_at >= 1) && (ack_at <= TMO);
            n = acked ? ack_at : TMO;
            for (int i = 0; i < n; i++) begin
               exp_len++; exp_v[exp_len] = cv | B_REQ;
            end
            m_stall += acked ? n - 1 : n;
            if (!acked) begin
               exp_len++; exp_v[exp_len] = B_RDY | B_BERR;
            end else begin
               if (op == 6'h23) begin
                  exp_len++; exp_v[exp_len] = cv | B_RW;
               end
               exp_len++; exp_v[exp_len] = B_RDY;
               m_retired++;
            end
         end
      end
   endtask

   // Accept one op, then record len cycles while injecting ignorable noise on idle inputs.
   task automatic run_op(input logic [5:0] op, input bit zero, input int ack_at, input int len);
      int w;
      w = 0;
      @(negedge clk);
      while (!instr_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      if (!instr_ready) begin
         n_checks++; n_fail++;
         $display("FAIL accept_wait: instr_ready=%0b, required 1 within 20 cycles", instr_ready);
      end
      instr_valid = 1'b1;
      opcode = op;
      Zero = 1'($urandom_range(0, 1));
      mem_ack = 1'($urandom_range(0, 1));
      for (int c = 1; c <= len; c++) begin
         @(negedge clk);
         obs_v[c] = pack_obs();
         mem_ack = (ack_at > 0 && c == 2 + ack_at) ? 1'b1 : (c <= 2 ? 1'($urandom_range(0, 1)) : 1'b0);
         Zero = (c == 2) ? zero : 1'($urandom_range(0, 1));
         if (!obs_v[c][11]) begin
            instr_valid = 1'($urandom_range(0, 1));
            opcode = 6'($urandom);
         end else begin
            instr_valid = 1'b0;
         end
      end
      mem_ack = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      instr_valid = 1'b1; opcode = 6'h00; Zero = 1'b1; mem_ack = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (pack_obs() !== 12'h000) begin
         n_fail++; $display("FAIL reset_outputs: got %03h expected 000", pack_obs());
      end
`ifdef EU_SEQ_PERF_EN
      n_checks++;
      if (retired_cnt !== 32'd0 || stall_cnt !== 32'd0) begin
         n_fail++; $display("FAIL reset_perf: retired=%0d stall=%0d expected 0 0", retired_cnt, stall_cnt);
      end
`endif
      instr_valid = 1'b0; mem_ack = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if (pack_obs() !== B_RDY) begin
         n_fail++; $display("FAIL reset_release: got %03h expected %03h", pack_obs(), B_RDY);
      end
      m_retired = 0; m_stall = 0;
   endtask

   task automatic test_alu();
      logic [5:0] ops [2];
      ops[0] = 6'h00; ops[1] = 6'h08;
      for (int k = 0; k < 2; k++) begin
         model(ops[k], 1'b0, 0);
         run_op(ops[k], 1'b0, 0, exp_len);
         for (int c = 1; c <= exp_len; c++) begin
            n_checks++;
            if (obs_v[c] !== exp_v[c]) begin
               n_fail++; $display("FAIL alu op=%02h c=%0d: got %03h expected %03h", ops[k], c, obs_v[c], exp_v[c]);
            end
         end
      end
   endtask

   task automatic test_lw();
      int acks [2];
      acks[0] = 3; acks[1] = TMO;
      for (int k = 0; k < 2; k++) begin
         model(6'h23, 1'b0, acks[k]);
         run_op(6'h23, 1'b0, acks[k], exp_len);
         for (int c = 1; c <= exp_len; c++) begin
            n_checks++;
            if (obs_v[c] !== exp_v[c]) begin
               n_fail++; $display("FAIL lw ack=%0d c=%0d: got %03h expected %03h", acks[k], c, obs_v[c], exp_v[c]);
            end
         end
      end
   endtask

   task automatic test_beq();
      for (int z = 1; z >= 0; z--) begin
         model(6'h04, z[0], 0);
         run_op(6'h04, z[0], 0, exp_len);
         for (int c = 1; c <= exp_len; c++) begin
            n_checks++;
            if (obs_v[c] !== exp_v[c]) begin
               n_fail++; $display("FAIL beq zero=%0d c=%0d: got %03h expected %03h", z, c, obs_v[c], exp_v[c]);
            end
         end
      end
   endtask

   task automatic test_sw_timeout();
      model(6'h2B, 1'b0, 0);
      run_op(6'h2B, 1'b0, 0, exp_len);
      for (int c = 1; c <= exp_len; c++) begin
         n_checks++;
         if (obs_v[c] !== exp_v[c]) begin
            n_fail++; $display("FAIL sw_timeout c=%0d: got %03h expected %03h", c, obs_v[c], exp_v[c]);
         end
      end
   endtask

   task automatic test_illegal();
      model(6'h3F, 1'b0, 0);
      run_op(6'h3F, 1'b0, 0, exp_len);
      for (int c = 1; c <= exp_len; c++) begin
         n_checks++;
         if (obs_v[c] !== exp_v[c]) begin
            n_fail++; $display("FAIL illegal c=%0d: got %03h expected %03h", c, obs_v[c], exp_v[c]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [5:0] op;
      bit         z;
      int         ack;
      for (int t = 0; t < 40; t++) begin
         case ($urandom_range(0, 5))
            0: op = 6'h00;
            1: op = 6'h08;
            2: op = 6'h23;
            3: op = 6'h2B;
            4: op = 6'h04;
            default: begin
               op = 6'($urandom);
               while (supported(op)) op = 6'($urandom);
            end
         endcase
         z = 1'($urandom_range(0, 1));
         ack = $urandom_range(0, TMO + 2);
         model(op, z, ack);
         run_op(op, z, ack, exp_len);
         for (int c = 1; c <= exp_len; c++) begin
            n_checks++;
            if (obs_v[c] !== exp_v[c]) begin
               n_fail++; $display("FAIL rand t=%0d op=%02h ack=%0d c=%0d: got %03h expected %03h",
                                  t, op, ack, c, obs_v[c], exp_v[c]);
            end
         end
`ifdef EU_SEQ_PERF_EN
         n_checks++;
         if (retired_cnt !== m_retired || stall_cnt !== m_stall) begin
            n_fail++; $display("FAIL rand_perf t=%0d: retired=%0d stall=%0d expected %0d %0d",
                               t, retired_cnt, stall_cnt, m_retired, m_stall);
         end
`endif
      end
   endtask

   task automatic test_reset_mid_mem();
      run_op(6'h23, 1'b0, 0, 3);
      n_checks++;
      if (obs_v[3] !== (ctl_of(6'h23) | B_REQ)) begin
         n_fail++; $display("FAIL mid_mem_before_reset: got %03h expected %03h", obs_v[3], ctl_of(6'h23) | B_REQ);
      end
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      n_checks++;
      if (pack_obs() !== 12'h000) begin
         n_fail++; $display("FAIL mid_mem_reset: got %03h expected 000", pack_obs());
      end
`ifdef EU_SEQ_PERF_EN
      n_checks++;
      if (retired_cnt !== 32'd0) begin
         n_fail++; $display("FAIL mid_mem_reset_perf: retired=%0d expected 0", retired_cnt);
      end
`endif
      m_retired = 0; m_stall = 0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if (pack_obs() !== B_RDY) begin
         n_fail++; $display("FAIL mid_mem_release: got %03h expected %03h", pack_obs(), B_RDY);
      end
   endtask

   initial begin
      rst_n = 1'b0; instr_valid = 1'b0; opcode = '0; Zero = 1'b0; mem_ack = 1'b0;
      test_reset();
      test_alu();
      test_lw();
      test_beq();
      test_sw_timeout();
      test_illegal();
      test_back_to_back();
      test_reset_mid_mem();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
      $fatal(1);
   end

endmodule
